jk_cmd_seq: RTL and testbench

JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

---
 rtl/jk_cmd_seq_if.sv | 30 +++
 rtl/jk_cmd_seq.sv | 157 +++++++++++++++
 tb/tb_jk_cmd_seq.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_cmd_seq_if.sv
// Command, drive and status bundle for jk_cmd_seq.
// master = command source / plant side, slave = the sequencer.
interface jk_cmd_seq_if #(
    parameter int DEPTH = 4,
    parameter int LENW  = 4
);
    logic                     cmd_valid;
    logic [1:0]               cmd_op;
    logic [LENW-1:0]          cmd_len;
    logic                     cmd_ready;
    logic                     abort;
    logic                     q_fb;
    logic                     j;
    logic                     k;
    logic                     busy;
    logic                     done;
    logic                     q_cap;
    logic [$clog2(DEPTH):0]   level;
    logic                     mismatch;

    modport master (
        output cmd_valid, cmd_op, cmd_len, abort, q_fb,
        input  cmd_ready, j, k, busy, done, q_cap, level, mismatch
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, abort, q_fb,
        output cmd_ready, j, k, busy, done, q_cap, level, mismatch
    );
endinterface

// File: rtl/jk_cmd_seq.sv
// Queued command sequencer driving a downstream JK flip-flop for a timed number of cycles.
// Optional expected-value check on set/reset commands: define JK_CMD_SEQ_CHECK_EN.
module jk_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int LENW  = 4
) (
    input  logic          clk,
    input  logic          rstlow,
    jk_cmd_seq_if.slave   bus
);
    localparam int PTRW = $clog2(DEPTH);
    localparam int LVLW = PTRW + 1;
    localparam int ENTW = LENW + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        REPORT = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ENTW-1:0]   mem_q [DEPTH];
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVLW-1:0]   level_q, level_d;
    logic [1:0]        op_q, op_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic              j_q, j_d, k_q, k_d;
    logic              done_q, done_d;
    logic              q_cap_q, q_cap_d;
    logic              full, push, pop;

    assign full  = (level_q == LVLW'(DEPTH));
    assign push  = bus.cmd_valid && !full;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        q_cap_d  = q_cap_q;
        j_d      = 1'b0;
        k_d      = 1'b0;
        done_d   = 1'b0;
        pop      = 1'b0;

        // j/k are computed for the state being entered so the flops line up with it.
        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop           = 1'b1;
                    {op_d, cnt_d} = mem_q[rd_ptr_q];
                    rd_ptr_d      = rd_ptr_q + PTRW'(1);
                    {j_d, k_d}    = op_d;
                    state_d       = DRIVE;
                end
            end
            DRIVE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = SETTLE;
                end else begin
                    cnt_d      = cnt_q - LENW'(1);
                    {j_d, k_d} = op_q;
                end
            end
            SETTLE: begin
                state_d = REPORT;
                done_d  = 1'b1;
            end
            REPORT: begin
                state_d = IDLE;
                q_cap_d = bus.q_fb;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVLW'(1);
            2'b01:   level_d = level_q - LVLW'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstlow) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            op_q     <= 2'b00;
            cnt_q    <= '0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            done_q   <= 1'b0;
            q_cap_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            j_q      <= j_d;
            k_q      <= k_d;
            done_q   <= done_d;
            q_cap_q  <= q_cap_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and level alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_op, bus.cmd_len};
        end
    end

`ifdef JK_CMD_SEQ_CHECK_EN
    logic mismatch_q, mismatch_d;

    // Only set and reset have a defined expected q; hold and toggle clear the flag.
    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q == REPORT) begin
            unique case (op_q)
                2'b10:   mismatch_d = !bus.q_fb;
                2'b01:   mismatch_d = bus.q_fb;
                default: mismatch_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstlow) mismatch_q <= 1'b0;
        else         mismatch_q <= mismatch_d;
    end

    assign bus.mismatch = mismatch_q;
`else
    assign bus.mismatch = 1'b0;
`endif

    assign bus.cmd_ready = !full;
    assign bus.level     = level_q;
    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.q_cap     = q_cap_q;
endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: a transaction-level model (command queue plus per-command
// age in cycles) predicts every output each cycle; a JK flip-flop plant closes the loop.
module tb_jk_cmd_seq;
    localparam int DEPTH = 4;
    localparam int LENW  = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct {
        logic [1:0] op;
        int         len;
    } cmd_t;

    typedef logic [6+LW:0] vec_t;

    logic clk = 1'b0;
    logic rstlow;
    bit   plant_q;
    bit   force_en;
    bit   force_val;

    jk_cmd_seq_if #(.DEPTH(DEPTH), .LENW(LENW)) bus ();

    jk_cmd_seq #(.DEPTH(DEPTH), .LENW(LENW)) dut (
        .clk    (clk),
        .rstlow (rstlow),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    assign bus.q_fb = force_en ? force_val : plant_q;

    // Reference model state: a command is "active" for len+3 cycles after its pop,
    // ages 0..len drive, len+1 settles, len+2 reports.
    cmd_t m_fifo[$];
    cmd_t m_cur;
    bit   m_active;
    int   m_age;
    bit   m_qexp;
    bit   m_qcap;
    bit   m_mm;

    cmd_t tx_q[$];
    int   n_cmp;
    int   n_bad;

    function automatic bit jk_next(input bit q, input logic [1:0] jk);
        case (jk)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    function automatic logic [1:0] exp_jk();
        return (m_active && m_age <= m_cur.len) ? m_cur.op : 2'b00;
    endfunction

    function automatic vec_t exp_vec();
        return {exp_jk(), m_active, (m_active && m_age == m_cur.len + 2), m_qcap, m_mm,
                (m_fifo.size() < DEPTH), LW'(m_fifo.size())};
    endfunction

    function automatic vec_t obs_vec();
        return {bus.j, bus.k, bus.busy, bus.done, bus.q_cap, bus.mismatch, bus.cmd_ready, bus.level};
    endfunction

    task automatic model_edge();
        bit         push;
        bit         qfb;
        logic [1:0] ejk;
        cmd_t       c;
        ejk    = exp_jk();
        qfb    = force_en ? force_val : m_qexp;
        push   = bus.cmd_valid && (m_fifo.size() < DEPTH);
        m_qexp = jk_next(m_qexp, ejk);
        if (!rstlow) begin
            m_fifo.delete();
            m_active = 1'b0;
            m_qcap   = 1'b0;
            m_mm     = 1'b0;
            return;
        end
        if (m_active) begin
            if (m_age <= m_cur.len && bus.abort) begin
                m_active = 1'b0;
            end else if (m_age == m_cur.len + 2) begin
                m_qcap   = qfb;
`ifdef JK_CMD_SEQ_CHECK_EN
                m_mm     = (m_cur.op == 2'b10) ? !qfb : (m_cur.op == 2'b01) ? qfb : 1'b0;
`endif
                m_active = 1'b0;
            end else begin
                m_age++;
            end
        end else if (m_fifo.size() > 0) begin
            m_cur    = m_fifo.pop_front();
            m_active = 1'b1;
            m_age    = 0;
        end
        if (push) begin
            c.op  = bus.cmd_op;
            c.len = int'(bus.cmd_len);
            m_fifo.push_back(c);
        end
    endtask

    task automatic step();
        logic [1:0] jk_pre;
        jk_pre = {bus.j, bus.k};
        model_edge();
        @(posedge clk);
        #1;
        plant_q = jk_next(plant_q, jk_pre);
    endtask

    task automatic tick();
        bit acc;
        if (tx_q.size() > 0) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = tx_q[0].op;
            bus.cmd_len   = LENW'(tx_q[0].len);
        end else begin
            bus.cmd_valid = 1'b0;
        end
        acc = bus.cmd_valid && (bus.cmd_ready === 1'b1);
        step();
        if (acc) void'(tx_q.pop_front());
    endtask

    function automatic cmd_t mk(input logic [1:0] op, input int len);
        cmd_t c;
        c.op  = op;
        c.len = len;
        return c;
    endfunction

    task automatic test_reset();
        rstlow = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_hold got=%b want=%b", obs_vec(), exp_vec());
        end
        rstlow = 1'b1;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_release got=%b want=1", bus.cmd_ready);
        end
        tick();
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_idle got=%b want=%b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_set_len2();
        int j_cycles = 0;
        int dones    = 0;
        tx_q.push_back(mk(2'b10, 2));
        for (int c = 0; c < 10; c++) begin
            tick();
            if ({bus.j, bus.k} === 2'b10) j_cycles++;
            if (bus.done === 1'b1) dones++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL set_len2 cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (j_cycles != 3 || dones != 1 || bus.q_cap !== 1'b1) begin
            n_bad++;
            $display("FAIL set_len2_summary drive=%0d done=%0d q_cap=%b want 3/1/1", j_cycles, dones, bus.q_cap);
        end
    endtask

    task automatic test_fifo_full();
        int dones    = 0;
        bit saw_full = 1'b0;
        for (int i = 0; i < 5; i++) tx_q.push_back(mk(2'($urandom_range(0, 3)), 1 + (i % 3)));
        for (int c = 0; c < 70; c++) begin
            tick();
            if (bus.level === LW'(DEPTH) && bus.cmd_ready === 1'b0) saw_full = 1'b1;
            if (bus.done === 1'b1) dones++;
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL fifo_full cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (!saw_full || dones != 5 || bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fifo_full_summary saw_full=%0d done=%0d busy=%b want 1/5/0", saw_full, dones, bus.busy);
        end
    endtask

    task automatic test_toggle();
        bit caps[$];
        bit prev_done = 1'b0;
        tx_q.push_back(mk(2'b01, 0));
        tx_q.push_back(mk(2'b11, 0));
        tx_q.push_back(mk(2'b11, 0));
        for (int c = 0; c < 30; c++) begin
            tick();
            if (prev_done) caps.push_back(bus.q_cap);
            prev_done = (bus.done === 1'b1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL toggle cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (caps.size() != 3 || caps[0] != 1'b0 || caps[1] != 1'b1 || caps[2] != 1'b0) begin
            n_bad++;
            $display("FAIL toggle_caps got n=%0d caps=%p want 0,1,0", caps.size(), caps);
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        bit ab_drive;
        bit ab_other;
        tx_q.push_back(mk(2'b01, 5));
        tx_q.push_back(mk(2'b10, 1));
        for (int c = 0; c < 30; c++) begin
            ab_drive  = m_active && m_cur.op == 2'b01 && m_cur.len == 5 && m_age == 1;
            ab_other  = m_active && m_cur.op == 2'b10 && m_age == m_cur.len + 1;
            bus.abort = ab_drive || ab_other;
            tick();
            bus.abort = 1'b0;
            if (bus.done === 1'b1) dones++;
            if (ab_drive) begin
                n_cmp++;
                if ({bus.j, bus.k, bus.busy, bus.done} !== 4'b0000) begin
                    n_bad++;
                    $display("FAIL abort_next got jkbd=%b want 0000", {bus.j, bus.k, bus.busy, bus.done});
                end
            end
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL abort cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (dones != 1 || bus.q_cap !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_summary done=%0d q_cap=%b want 1/1", dones, bus.q_cap);
        end
    endtask

    task automatic test_reset_mid();
        bit reached = 1'b0;
        for (int i = 0; i < 4; i++) tx_q.push_back(mk(2'($urandom_range(0, 3)), 7));
        for (int c = 0; c < 20 && !reached; c++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_mid_fill cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
            reached = m_active && m_fifo.size() == 3;
        end
        n_cmp++;
        if (!reached || bus.level !== LW'(3)) begin
            n_bad++;
            $display("FAIL reset_mid_setup level=%0d want 3", bus.level);
        end
        rstlow = 1'b0;
        tx_q.delete();
        tick();
        rstlow = 1'b1;
        n_cmp++;
        if ({bus.j, bus.k, bus.busy, bus.done, bus.mismatch, bus.q_cap} !== 6'b0 || bus.level !== '0) begin
            n_bad++;
            $display("FAIL reset_mid got jkbdmq=%b level=%0d want 000000/0",
                     {bus.j, bus.k, bus.busy, bus.done, bus.mismatch, bus.q_cap}, bus.level);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_mid_after cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_mismatch();
        bit exp_mm;
`ifdef JK_CMD_SEQ_CHECK_EN
        exp_mm = 1'b1;
`else
        exp_mm = 1'b0;
`endif
        force_en  = 1'b1;
        force_val = 1'b0;
        tx_q.push_back(mk(2'b10, 1));
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL mismatch cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (bus.mismatch !== exp_mm || bus.q_cap !== 1'b0) begin
            n_bad++;
            $display("FAIL mismatch_flag got mm=%b q_cap=%b want mm=%b q_cap=0", bus.mismatch, bus.q_cap, exp_mm);
        end
        force_en = 1'b0;
        tx_q.push_back(mk(2'b10, 0));
        for (int c = 0; c < 8; c++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL mismatch_clear cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (tx_q.size() == 0 && $urandom_range(0, 2) != 0)
                tx_q.push_back(mk(2'($urandom_range(0, 3)), int'($urandom_range(0, 3))));
            bus.abort = ($urandom_range(0, 9) == 0);
            rstlow    = ($urandom_range(0, 99) != 0);
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
        end
        bus.abort = 1'b0;
        rstlow    = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_drain cyc=%0d got=%b want=%b", c, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.level !== '0) begin
            n_bad++;
            $display("FAIL random_idle busy=%b level=%0d want 0/0", bus.busy, bus.level);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rstlow        = 1'b0;
        plant_q       = 1'b0;
        force_en      = 1'b0;
        force_val     = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_len   = '0;
        bus.abort     = 1'b0;
        m_active      = 1'b0;
        m_age         = 0;
        m_qexp        = 1'b0;
        m_qcap        = 1'b0;
        m_mm          = 1'b0;
        m_cur         = mk(2'b00, 0);

        test_reset();
        test_set_len2();
        test_fifo_full();
        test_toggle();
        test_abort();
        test_reset_mid();
        test_mismatch();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
